// File: rtl/cmd_issuer.sv
// cmd_issuer: buffers DRAM requests in a small FIFO and issues ACT/PRE/RD/WR
// commands for the head request, tracking open rows per bank group/bank.
// Optional closed-page policy: define CMD_ISSUER_AUTO_PRE_EN.
// Handshake: the push side has no backpressure other than 'full'; a push is
// accepted on a rising edge with wr_en=1 and full=0, otherwise it is dropped.
// Commands are one-cycle pulses on cmd_valid; cmd is NOP whenever cmd_valid=0.
module cmd_issuer #(
  parameter int INDEX_BITS = 7,
  parameter int RA_BITS    = 16,
  parameter int CA_BITS    = 10,
  parameter int DATA_BITS  = 16,
  parameter int DEPTH      = 4,
  parameter int T_RCD      = 4,
  parameter int T_RP       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  type_i,
  input  logic [DATA_BITS-1:0]  data_i,
  input  logic [INDEX_BITS-1:0] idx_i,
  input  logic [RA_BITS-1:0]    row_i,
  input  logic [CA_BITS-1:0]    col_i,
  input  logic [1:0]            ba_i,
  input  logic [1:0]            bg_i,
  output logic                  full,
  output logic                  cmd_valid,
  output logic [2:0]            cmd,
  output logic [1:0]            cmd_ba,
  output logic [1:0]            cmd_bg,
  output logic [RA_BITS-1:0]    cmd_row,
  output logic [CA_BITS-1:0]    cmd_col,
  output logic [DATA_BITS-1:0]  cmd_data,
  output logic [INDEX_BITS-1:0] cmd_idx
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int T_MAX = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int CNT_W = $clog2(T_MAX + 1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;

  typedef struct packed {
    logic                  typ;
    logic [DATA_BITS-1:0]  data;
    logic [INDEX_BITS-1:0] idx;
    logic [RA_BITS-1:0]    row;
    logic [CA_BITS-1:0]    col;
    logic [1:0]            ba;
    logic [1:0]            bg;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WAIT_RP, WAIT_RCD, AUTO_PRE} state_t;

  entry_t               mem_q [DEPTH];
  entry_t               in_entry;
  entry_t               head;
  logic [3:0]           hb;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic                 push, pop;
  logic                 head_rdy_q, head_rdy_d;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [15:0]          open_q, open_d;
  logic [RA_BITS-1:0]   row_tab_q [16];
  logic [RA_BITS-1:0]   row_tab_d [16];

  logic                 do_act, do_pre, do_rw;
  logic [3:0]           pre_bank;
  logic [RA_BITS-1:0]   pre_row;

`ifdef CMD_ISSUER_AUTO_PRE_EN
  logic                 ap_done_q, ap_done_d;
  logic [3:0]           ap_bank_q, ap_bank_d;
`endif

  logic                  cmd_valid_q, cmd_valid_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [1:0]            cmd_ba_q, cmd_ba_d, cmd_bg_q, cmd_bg_d;
  logic [RA_BITS-1:0]    cmd_row_q, cmd_row_d;
  logic [CA_BITS-1:0]    cmd_col_q, cmd_col_d;
  logic [DATA_BITS-1:0]  cmd_data_q, cmd_data_d;
  logic [INDEX_BITS-1:0] cmd_idx_q, cmd_idx_d;

  assign full     = (count_q == FULL_CNT);
  assign in_entry = '{typ: type_i, data: data_i, idx: idx_i, row: row_i,
                      col: col_i, ba: ba_i, bg: bg_i};
  assign head     = mem_q[rd_ptr_q];
  assign hb       = {head.bg, head.ba};

  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign cmd_ba    = cmd_ba_q;
  assign cmd_bg    = cmd_bg_q;
  assign cmd_row   = cmd_row_q;
  assign cmd_col   = cmd_col_q;
  assign cmd_data  = cmd_data_q;
  assign cmd_idx   = cmd_idx_q;

  // Buffer storage; entries are only read while the count marks them valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  // FIFO pointer/count bookkeeping; a push while full is dropped even on a pop.
  always_comb begin
    push     = wr_en && !full;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
  end

  // Scheduler: decide which command the head needs and track bank timing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    open_d    = open_q;
    row_tab_d = row_tab_q;
    pop       = 1'b0;
    do_act    = 1'b0;
    do_pre    = 1'b0;
    do_rw     = 1'b0;
    pre_bank  = hb;
    pre_row   = row_tab_q[hb];
`ifdef CMD_ISSUER_AUTO_PRE_EN
    ap_done_d = ap_done_q;
    ap_bank_d = ap_bank_q;
`endif
    case (state_q)
      IDLE: begin
        if (head_rdy_q && (count_q != '0)) begin
          if (open_q[hb] && (row_tab_q[hb] == head.row)) begin
            do_rw = 1'b1;
            pop   = 1'b1;
`ifdef CMD_ISSUER_AUTO_PRE_EN
            state_d   = AUTO_PRE;
            ap_done_d = 1'b0;
            ap_bank_d = hb;
`endif
          end else if (!open_q[hb]) begin
            do_act        = 1'b1;
            open_d[hb]    = 1'b1;
            row_tab_d[hb] = head.row;
            cnt_d         = '0;
            state_d       = WAIT_RCD;
          end else begin
            do_pre     = 1'b1;
            open_d[hb] = 1'b0;
            cnt_d      = '0;
            state_d    = WAIT_RP;
          end
        end
      end
      WAIT_RP: begin
        if (cnt_q == CNT_W'(T_RP - 1)) begin
          do_act        = 1'b1;
          open_d[hb]    = 1'b1;
          row_tab_d[hb] = head.row;
          cnt_d         = '0;
          state_d       = WAIT_RCD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_RCD: begin
        if (cnt_q == CNT_W'(T_RCD - 1)) begin
          do_rw   = 1'b1;
          pop     = 1'b1;
          cnt_d   = '0;
`ifdef CMD_ISSUER_AUTO_PRE_EN
          state_d   = AUTO_PRE;
          ap_done_d = 1'b0;
          ap_bank_d = hb;
`else
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      AUTO_PRE: begin
`ifdef CMD_ISSUER_AUTO_PRE_EN
        if (!ap_done_q) begin
          do_pre            = 1'b1;
          pre_bank          = ap_bank_q;
          pre_row           = row_tab_q[ap_bank_q];
          open_d[ap_bank_q] = 1'b0;
          ap_done_d         = 1'b1;
          cnt_d             = '0;
        end else if (cnt_q == CNT_W'(T_RP - 2)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    // Head is re-evaluated only one cycle after it settles in IDLE.
    head_rdy_d = (count_q != '0) && (state_d == IDLE) && !pop;
  end

  // Command bus next value; all fields are zero when nothing issues.
  always_comb begin
    cmd_valid_d = do_act || do_pre || do_rw;
    cmd_d       = CMD_NOP;
    cmd_ba_d    = '0;
    cmd_bg_d    = '0;
    cmd_row_d   = '0;
    cmd_col_d   = '0;
    cmd_data_d  = '0;
    cmd_idx_d   = '0;
    if (do_rw) begin
      cmd_d      = head.typ ? CMD_WR : CMD_RD;
      cmd_ba_d   = head.ba;
      cmd_bg_d   = head.bg;
      cmd_row_d  = head.row;
      cmd_col_d  = head.col;
      cmd_data_d = head.data;
      cmd_idx_d  = head.idx;
    end else if (do_act) begin
      cmd_d     = CMD_ACT;
      cmd_ba_d  = head.ba;
      cmd_bg_d  = head.bg;
      cmd_row_d = head.row;
    end else if (do_pre) begin
      cmd_d     = CMD_PRE;
      cmd_ba_d  = pre_bank[1:0];
      cmd_bg_d  = pre_bank[3:2];
      cmd_row_d = pre_row;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_rdy_q  <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      open_q      <= '0;
      for (int i = 0; i < 16; i++) row_tab_q[i] <= '0;
`ifdef CMD_ISSUER_AUTO_PRE_EN
      ap_done_q   <= 1'b0;
      ap_bank_q   <= '0;
`endif
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      cmd_ba_q    <= '0;
      cmd_bg_q    <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      cmd_data_q  <= '0;
      cmd_idx_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_rdy_q  <= head_rdy_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      open_q      <= open_d;
      row_tab_q   <= row_tab_d;
`ifdef CMD_ISSUER_AUTO_PRE_EN
      ap_done_q   <= ap_done_d;
      ap_bank_q   <= ap_bank_d;
`endif
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      cmd_ba_q    <= cmd_ba_d;
      cmd_bg_q    <= cmd_bg_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      cmd_data_q  <= cmd_data_d;
      cmd_idx_q   <= cmd_idx_d;
    end
  end

endmodule

// File: tb/tb_cmd_issuer.sv
// Bench for cmd_issuer with default parameters (T_RCD=4, T_RP=4, DEPTH=4).
// Observed commands are packed as {offset, cmd, bg, ba, row, col, data, idx}
// where offset counts clock edges from the push edge.
module tb_cmd_issuer;

  localparam logic [2:0] C_ACT = 3'd1;
  localparam logic [2:0] C_RD  = 3'd2;
  localparam logic [2:0] C_WR  = 3'd3;
  localparam logic [2:0] C_PRE = 3'd4;

  logic        clk, rst;
  logic        wr_en, type_i;
  logic [15:0] data_i;
  logic [6:0]  idx_i;
  logic [15:0] row_i;
  logic [9:0]  col_i;
  logic [1:0]  ba_i, bg_i;
  logic        full, cmd_valid;
  logic [2:0]  cmd;
  logic [1:0]  cmd_ba, cmd_bg;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [15:0] cmd_data;
  logic [6:0]  cmd_idx;

  typedef struct {
    logic        typ;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [15:0] row;
    logic [9:0]  col;
    logic [15:0] data;
    logic [6:0]  idx;
    logic        exp_pre;
    logic [15:0] pre_row;
    logic        exp_act;
    int          rw_off;
  } vec_t;

  vec_t        vecs [9];
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          base_cyc = 0;
  int          nop_bad = 0;
  logic        full_seen = 1'b0;

  cmd_issuer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .type_i(type_i), .data_i(data_i),
    .idx_i(idx_i), .row_i(row_i), .col_i(col_i), .ba_i(ba_i), .bg_i(bg_i),
    .full(full), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ba(cmd_ba),
    .cmd_bg(cmd_bg), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_data(cmd_data), .cmd_idx(cmd_idx)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pack(input int off, input logic [2:0] c,
                                       input logic [1:0] bg, input logic [1:0] ba,
                                       input logic [15:0] row, input logic [9:0] col,
                                       input logic [15:0] data, input logic [6:0] idx);
    logic [7:0] o8;
    o8 = 8'(off);
    if (c == C_ACT || c == C_PRE) begin
      col = '0; data = '0; idx = '0;
    end
    return {o8, c, bg, ba, row, col, data, idx};
  endfunction

  // Monitor: log every issued command, sampled 1 time unit after the edge
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (cmd_valid)
        obs_q.push_back(pack(cyc - base_cyc, cmd, cmd_bg, cmd_ba, cmd_row,
                             cmd_col, cmd_data, cmd_idx));
      if (!cmd_valid && cmd != 3'd0) nop_bad++;
      if (full) full_seen = 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic typ, input logic [1:0] bg, input logic [1:0] ba,
                       input logic [15:0] row, input logic [9:0] col,
                       input logic [15:0] data, input logic [6:0] idx);
    wr_en = 1'b1; type_i = typ; bg_i = bg; ba_i = ba;
    row_i = row; col_i = col; data_i = data; idx_i = idx;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    logic [2:0] rw;
    rw = v.typ ? C_WR : C_RD;
    exp_q.delete();
`ifdef CMD_ISSUER_AUTO_PRE_EN
    exp_q.push_back(pack(2, C_ACT, v.bg, v.ba, v.row, 0, 0, 0));
    exp_q.push_back(pack(6, rw, v.bg, v.ba, v.row, v.col, v.data, v.idx));
    exp_q.push_back(pack(7, C_PRE, v.bg, v.ba, v.row, 0, 0, 0));
`else
    if (v.exp_pre) exp_q.push_back(pack(2, C_PRE, v.bg, v.ba, v.pre_row, 0, 0, 0));
    if (v.exp_act) exp_q.push_back(pack(v.exp_pre ? 6 : 2, C_ACT, v.bg, v.ba, v.row, 0, 0, 0));
    exp_q.push_back(pack(v.rw_off, rw, v.bg, v.ba, v.row, v.col, v.data, v.idx));
`endif
    obs_q.delete();
    full_seen = 1'b0;
    base_cyc = cyc + 1;
    drive(v.typ, v.bg, v.ba, v.row, v.col, v.data, v.idx);
    @(posedge clk);
    #1 wr_en = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    check($sformatf("%s_ncmd", name), 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) check($sformatf("%s_cmd%0d", name, i), obs_q[i], exp_q[i]);
    check($sformatf("%s_full_low", name), 64'(full_seen), 64'd0);
  endtask

  initial begin
    // typ bg ba row col data idx | exp_pre pre_row exp_act rw_off
    vecs[0] = '{1'b1, 2'd1, 2'd2, 16'h0010, 10'h005, 16'hBEEF, 7'd1, 1'b0, 16'h0000, 1'b1, 6};
    vecs[1] = '{1'b0, 2'd1, 2'd2, 16'h0010, 10'h007, 16'h0000, 7'd2, 1'b0, 16'h0000, 1'b0, 2};
    vecs[2] = '{1'b0, 2'd1, 2'd2, 16'h0020, 10'h009, 16'h0000, 7'd3, 1'b1, 16'h0010, 1'b1, 10};
    vecs[3] = '{1'b1, 2'd0, 2'd0, 16'h0030, 10'h011, 16'h1234, 7'd4, 1'b0, 16'h0000, 1'b1, 6};
    vecs[4] = '{1'b0, 2'd1, 2'd2, 16'h0020, 10'h0AA, 16'h0000, 7'd5, 1'b0, 16'h0000, 1'b0, 2};
    vecs[5] = '{1'b1, 2'd3, 2'd3, 16'hFFFF, 10'h3FF, 16'hFFFF, 7'h7F, 1'b0, 16'h0000, 1'b1, 6};
    vecs[6] = '{1'b0, 2'd0, 2'd0, 16'h0030, 10'h000, 16'h0000, 7'd6, 1'b0, 16'h0000, 1'b0, 2};
    // after the mid-sequence reset every bank is closed again
    vecs[7] = '{1'b0, 2'd1, 2'd2, 16'h0020, 10'h001, 16'h0000, 7'd7, 1'b0, 16'h0000, 1'b1, 6};
    vecs[8] = '{1'b1, 2'd2, 2'd1, 16'h0040, 10'h002, 16'h5A5A, 7'd8, 1'b0, 16'h0000, 1'b1, 6};

    rst = 1'b1; wr_en = 1'b0; type_i = 1'b0; data_i = '0; idx_i = '0;
    row_i = '0; col_i = '0; ba_i = '0; bg_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_buses", 64'({cmd, cmd_ba, cmd_bg, cmd_row, cmd_col, cmd_data, cmd_idx}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #2;
    check("post_rst_valid", 64'(cmd_valid), 64'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting tRCD: ACT visible, then reset kills it immediately
    obs_q.delete();
    base_cyc = cyc + 1;
    drive(1'b1, 2'd2, 2'd1, 16'h0040, 10'h003, 16'hA5A5, 7'd9);
    @(posedge clk);
    #1 wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rstmid_act_seen", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() > 0)
      check("rstmid_act", obs_q[0], pack(2, C_ACT, 2'd2, 2'd1, 16'h0040, 0, 0, 0));
    rst = 1'b1;
    #1;
    check("rstmid_valid", 64'(cmd_valid), 64'd0);
    check("rstmid_buses", 64'({cmd, cmd_ba, cmd_bg, cmd_row, cmd_col, cmd_data, cmd_idx}), 64'd0);
    check("rstmid_full", 64'(full), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    obs_q.delete();
    repeat (12) @(posedge clk);
    #2;
    check("rstmid_no_cmd", 64'(obs_q.size()), 64'd0);

    run_vec(vecs[7], "post_rst_reopen");
    run_vec(vecs[8], "post_rst_same_row");

    // Five back-to-back pushes to a closed bank: fourth fills, fifth dropped
    obs_q.delete();
    base_cyc = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      drive(k % 2 == 1, 2'd0, 2'd1, 16'h0050, 10'(k), 16'(k), 7'(10 + k));
      @(posedge clk);
      #1;
      if (k == 2) check("full_after_3", 64'(full), 64'd0);
      if (k == 3) check("full_after_4", 64'(full), 64'd1);
    end
    wr_en = 1'b0;
    check("full_after_5", 64'(full), 64'd1);
    repeat (80) @(posedge clk);
    #2;
    check("drain_full_low", 64'(full), 64'd0);
    begin
      logic [6:0] got_idx[$];
      logic [63:0] w;
      logic [2:0] c;
      for (int i = 0; i < obs_q.size(); i++) begin
        w = obs_q[i];
        c = w[55:53];
        if (c == C_RD || c == C_WR) got_idx.push_back(w[6:0]);
      end
      check("burst_nrw", 64'(got_idx.size()), 64'd4);
      for (int i = 0; i < 4; i++)
        if (i < got_idx.size()) check($sformatf("burst_idx%0d", i), 64'(got_idx[i]), 64'(10 + i));
    end

    check("nop_when_invalid", 64'(nop_bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cmd_issuer.md
CMD_ISSUER -- requirements
Module: cmd_issuer

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 7, request index width.
REQ-002 SHALL have parameter RA_BITS, default 16, row address width.
REQ-003 SHALL have parameter CA_BITS, default 10, column address width.
REQ-004 SHALL have parameter DATA_BITS, default 16, write data width.
REQ-005 SHALL have parameter DEPTH, default 4 (power of two, at least 2), input buffer entries.
REQ-006 SHALL have parameter T_RCD, default 4 (at least 2), ACT-to-RD/WR spacing in cycles.
REQ-007 SHALL have parameter T_RP, default 4 (at least 2), PRE-to-ACT spacing in cycles.
REQ-008 One clock; reset is asynchronous and active-high: port clk, input, 1, rising-edge clock.
REQ-009 Port rst, input, 1, asynchronous active-high reset.
REQ-010 Ports wr_en (1), type_i (1, 1=write), data_i (DATA_BITS), idx_i (INDEX_BITS), row_i (RA_BITS), col_i (CA_BITS), ba_i (2), bg_i (2), all inputs: push side fed by the arbiter.
REQ-011 Port full, output, 1, high when buffer count equals DEPTH.
REQ-012 Ports cmd_valid (1) and cmd (3: 1=ACT, 2=RD, 3=WR, 4=PRE, 0=NOP), outputs.
REQ-013 Ports cmd_ba (2), cmd_bg (2), cmd_row (RA_BITS), cmd_col (CA_BITS), cmd_data (DATA_BITS), cmd_idx (INDEX_BITS), outputs, all registered.

Function
REQ-014 SHALL push the input fields into a DEPTH-entry FIFO on a clock edge with wr_en=1 and full=0; a push while full SHALL be dropped, even if a pop occurs in the same cycle.
REQ-015 SHALL keep a 16-entry open-row table, indexed {bg,ba}, each entry holding an open bit and a row.
REQ-016 SHALL implement FSM states IDLE, WAIT_RP, WAIT_RCD and AUTO_PRE.
REQ-017 In IDLE with a non-empty FIFO, the head SHALL be evaluated as follows: row hit issues RD/WR and pops; bank closed issues ACT, sets open and row, and goes to WAIT_RCD; row miss issues PRE, clears open, and goes to WAIT_RP.
REQ-018 WAIT_RP SHALL count T_RP-1 cycles after PRE, then issue ACT and enter WAIT_RCD.
REQ-019 WAIT_RCD SHALL count T_RCD-1 cycles after ACT, then issue RD/WR for the head, pop, and return to IDLE.
REQ-020 Commands SHALL be registered: cmd_valid is high for exactly one cycle, in the cycle after the issuing decision; cmd_valid=0 implies cmd=0.
REQ-021 Latency, push edge to RD/WR with cmd_valid high: row hit 2 cycles; closed bank 2+T_RCD; row miss 2+T_RP+T_RCD. The FIFO SHALL have no bypass path.
REQ-022 For PRE and ACT, cmd_row SHALL carry the table row and head row respectively; cmd_col, cmd_data and cmd_idx SHALL be valid only for RD/WR.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH; full SHALL be derived from the registered count.
REQ-024 At most one command SHALL issue per cycle; the head SHALL NOT change while in WAIT_RP or WAIT_RCD.

Reset
REQ-025 rst=1 SHALL asynchronously clear the FIFO count and pointers, all open bits, the counters and cmd_valid, set cmd=0 and state=IDLE, and zero all cmd_* buses; full SHALL read 0.
REQ-026 rst asserted mid-sequence SHALL abandon the in-flight request with no further command issued; the first command after release SHALL be the earliest ACT.

Configuration
REQ-027 Macro CMD_ISSUER_AUTO_PRE_EN defined SHALL select closed-page policy: each RD/WR moves to AUTO_PRE, which issues PRE to the same bank next cycle, clears open, and waits T_RP-1 cycles before IDLE.
REQ-028 Without CMD_ISSUER_AUTO_PRE_EN, open-page policy SHALL apply: rows stay open until a miss, and the AUTO_PRE state is unreachable.

Verification (T_RCD=4, T_RP=4, DEPTH=4)
REQ-029 Reset, then one write push with bg=1, ba=2, row=0x0010, col=0x005, data=0xBEEF: ACT row 0x0010 at push+2, WR col 0x005 data 0xBEEF at push+6, full=0 throughout.
REQ-030 Second push to the same bank, row 0x0010, after the first completes: RD issued 2 cycles after push with no ACT.
REQ-031 Push to the same bank with row 0x0020: PRE row 0x0010 at push+2, ACT 0x0020 at push+6, RD at push+10.
REQ-032 Five back-to-back pushes with no drain: full=1 after the 4th push edge, 5th dropped; exactly 4 RD/WR commands later observed with idx in order.
REQ-033 rst pulsed during WAIT_RCD: cmd_valid=0 immediately, all buses 0; a new push afterwards yields ACT (not RD) even if the same row.
REQ-034 With CMD_ISSUER_AUTO_PRE_EN: each WR is followed by PRE to the same bank the next cycle, and a repeat same-row request gets a fresh ACT.
